tri_sequencer: RTL and testbench

Triangle sequencer with optional perspective projection. Sits between the model RAM loaded by ROM2RAM and the filled_tris rasterizer. It fetches each triangle's nine words (x1,y1,z1,x2,y2,z2,x3,y3,z3), optionally projects x,y by PROJ_D/z, presents stable vertices to filled_tris, launches it, and waits for its finish. It replaces the ad-hoc triangle-iteration logic around the rasterizer and holds the video-buffer write enable for the whole draw pass.

---
 rtl/tri_pkg.sv | 55 +++++
 rtl/tri_sequencer_if.sv | 26 ++
 rtl/seq_sdiv.sv | 71 +++++++
 rtl/tri_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_tri_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tri_pkg.sv
// Shared constants, FSM state type and vertex-index helpers for the triangle sequencer.
package tri_pkg;

  localparam int TRI_WORDS = 9;

  localparam int X1 = 0;
  localparam int Y1 = 1;
  localparam int Z1 = 2;
  localparam int X2 = 3;
  localparam int Y2 = 4;
  localparam int Z2 = 5;
  localparam int X3 = 6;
  localparam int Y3 = 7;
  localparam int Z3 = 8;

  localparam int N_DIVS = 6;

  // Divider latency: one load cycle, one cycle per quotient bit, one sign-fix cycle.
  function automatic int div_lat(input int w);
    return 2 * w + 2;
  endfunction

  localparam int DIV_LAT = div_lat(32);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PROJ,
    S_LAUNCH,
    S_WAIT,
    S_NEXT,
    S_FIN
  } state_t;

  // Divide number 0..5 walks x1,y1,x2,y2,x3,y3.
  function automatic logic [3:0] coord_idx(input logic [2:0] di);
    case (di)
      3'd0:    return 4'(X1);
      3'd1:    return 4'(Y1);
      3'd2:    return 4'(X2);
      3'd3:    return 4'(Y2);
      3'd4:    return 4'(X3);
      default: return 4'(Y3);
    endcase
  endfunction

  function automatic logic [3:0] z_idx(input logic [2:0] di);
    case (di)
      3'd0, 3'd1: return 4'(Z1);
      3'd2, 3'd3: return 4'(Z2);
      default:    return 4'(Z3);
    endcase
  endfunction

endpackage

// File: rtl/tri_sequencer_if.sv
// Model-RAM and rasterizer signals of the triangle sequencer.
// Semantics: ram_data carries the word addressed by ram_addr one cycle later;
// rast_reset is a one-cycle launch that consumes tx*/ty* (stable until the next
// launch); rast_finish is a level done flag from the rasterizer, stale for one
// cycle after a launch; vid_we gates video-buffer writes for the whole pass.
interface tri_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic        [ADDR_W-1:0] ram_addr;
  logic        [DATA_W-1:0] ram_data;
  logic signed [DATA_W-1:0] tx1, ty1, tx2, ty2, tx3, ty3;
  logic                     rast_reset;
  logic                     rast_finish;
  logic                     vid_we;

  modport master (
    output ram_addr, tx1, ty1, tx2, ty2, tx3, ty3, rast_reset, vid_we,
    input  ram_data, rast_finish
  );

  modport slave (
    input  ram_addr, tx1, ty1, tx2, ty2, tx3, ty3, rast_reset, vid_we,
    output ram_data, rast_finish
  );
endinterface

// File: rtl/seq_sdiv.sv
// Signed restoring divider, 2*DATA_W dividend by DATA_W divisor, fixed latency
// regardless of operands; quotient truncates toward zero, low DATA_W bits kept.
module seq_sdiv
  import tri_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       go,
  input  logic signed [2*DATA_W-1:0] dividend,
  input  logic signed [DATA_W-1:0]   divisor,
  output logic signed [DATA_W-1:0]   quotient,
  output logic                       q_valid,
  output logic                       dz
);

  localparam int ITERS = div_lat(DATA_W) - 2;
  localparam int CW    = $clog2(ITERS + 1);

  logic                  running;
  logic [CW-1:0]         cnt;
  logic [DATA_W-1:0]     rem;
  logic [2*DATA_W-1:0]   quo;
  logic [DATA_W-1:0]     dvs_mag;
  logic                  neg;
  logic                  zero;
  logic [DATA_W:0]       trial_in;
  logic [DATA_W:0]       diff;
  logic [2*DATA_W-1:0]   q_signed;

  always_comb begin
    trial_in = {rem, quo[2*DATA_W-1]};
    diff     = trial_in - {1'b0, dvs_mag};
    q_signed = neg ? -quo : quo;
    quotient = zero ? '0 : q_signed[DATA_W-1:0];
    q_valid  = running && (cnt == CW'(ITERS));
    dz       = zero;
  end

  // Operands are reduced to magnitudes at load; the sign is reapplied on the
  // way out so the result truncates toward zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      running <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs_mag <= '0;
      neg     <= 1'b0;
      zero    <= 1'b0;
    end else if (go) begin
      running <= 1'b1;
      cnt     <= '0;
      rem     <= '0;
      quo     <= dividend[2*DATA_W-1] ? -dividend : dividend;
      dvs_mag <= divisor[DATA_W-1] ? -divisor : divisor;
      neg     <= dividend[2*DATA_W-1] ^ divisor[DATA_W-1];
      zero    <= (divisor == '0);
    end else if (running) begin
      if (cnt == CW'(ITERS)) begin
        running <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
        rem <= diff[DATA_W] ? trial_in[DATA_W-1:0] : diff[DATA_W-1:0];
        quo <= {quo[2*DATA_W-2:0], ~diff[DATA_W]};
      end
    end
  end

endmodule

// File: rtl/tri_sequencer.sv
// Triangle sequencer: fetches nine-word triangles from model RAM, optionally
// projects x,y by PROJ_D/z, and launches the rasterizer once per triangle.
module tri_sequencer
  import tri_pkg::*;
#(
  parameter int                       ADDR_W = 8,
  parameter int                       DATA_W = 32,
  parameter logic signed [DATA_W-1:0] PROJ_D = 300
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] tri_count,
  input  logic              project_en,
  tri_sequencer_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic              div_err,
  output state_t            state_dbg
);

  localparam logic [2*DATA_W-1:0] PD_X = {{DATA_W{PROJ_D[DATA_W-1]}}, PROJ_D};

  state_t                   state;
  logic [3:0]               fcnt;
  logic [2:0]               di;
  logic                     proj_r;
  logic [ADDR_W-1:0]        base;
  logic [ADDR_W-1:0]        remaining;
  logic                     first_wait;
  logic                     div_go;
  logic signed [DATA_W-1:0] s [TRI_WORDS];

  logic signed [DATA_W-1:0]   coord_w;
  logic [2*DATA_W-1:0]        coord_x;
  logic signed [2*DATA_W-1:0] dividend;
  logic signed [DATA_W-1:0]   divisor;
  logic signed [DATA_W-1:0]   q_quot;
  logic                       q_valid;
  logic                       q_dz;
  logic                       launch_now;

  assign state_dbg = state;

  always_comb begin
    coord_w    = s[coord_idx(di)];
    coord_x    = {{DATA_W{coord_w[DATA_W-1]}}, coord_w};
    dividend   = $signed(coord_x * PD_X);
    divisor    = s[z_idx(di)];
    launch_now = ((state == S_FETCH) && (fcnt == 4'd9) && !proj_r) ||
                 ((state == S_PROJ) && q_valid && (di == 3'(N_DIVS - 1)));
  end

  seq_sdiv #(.DATA_W(DATA_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .go       (div_go),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (q_quot),
    .q_valid  (q_valid),
    .dz       (q_dz)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      fcnt           <= '0;
      di             <= '0;
      proj_r         <= 1'b0;
      base           <= '0;
      remaining      <= '0;
      first_wait     <= 1'b0;
      div_go         <= 1'b0;
      bus.ram_addr   <= '0;
      bus.tx1        <= '0;
      bus.ty1        <= '0;
      bus.tx2        <= '0;
      bus.ty2        <= '0;
      bus.tx3        <= '0;
      bus.ty3        <= '0;
      bus.rast_reset <= 1'b0;
      bus.vid_we     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      div_err        <= 1'b0;
      for (int i = 0; i < TRI_WORDS; i++) s[i] <= '0;
    end else begin
      bus.rast_reset <= 1'b0;
      done           <= 1'b0;
      div_go         <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= tri_count;
            proj_r    <= project_en;
            base      <= '0;
            div_err   <= 1'b0;
            fcnt      <= '0;
            if (tri_count == '0) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state        <= S_FETCH;
              bus.ram_addr <= '0;
              bus.vid_we   <= 1'b1;
              busy         <= 1'b1;
            end
          end
        end

        // Address leads data by one cycle, so word k lands in s[k] at fcnt=k+1.
        S_FETCH: begin
          if (fcnt != 4'd0) s[fcnt - 4'd1] <= bus.ram_data;
          if (fcnt < 4'd8) bus.ram_addr <= base + ADDR_W'(fcnt + 4'd1);
          if (fcnt == 4'd9) begin
            if (proj_r) begin
              state  <= S_PROJ;
              di     <= '0;
              div_go <= 1'b1;
            end
          end else begin
            fcnt <= fcnt + 4'd1;
          end
        end

        S_PROJ: begin
          if (q_valid) begin
            s[coord_idx(di)] <= q_quot;
            if (q_dz) div_err <= 1'b1;
            if (di != 3'(N_DIVS - 1)) begin
              di     <= di + 3'd1;
              div_go <= 1'b1;
            end
          end
        end

        S_LAUNCH: begin
          state      <= S_WAIT;
          first_wait <= 1'b1;
        end

        // The first WAIT cycle may still see the previous triangle's finish.
        S_WAIT: begin
          if (first_wait) first_wait <= 1'b0;
          else if (bus.rast_finish) state <= S_NEXT;
        end

        S_NEXT: begin
          base      <= base + ADDR_W'(TRI_WORDS);
          remaining <= remaining - 1'b1;
          if (remaining == ADDR_W'(1)) begin
            state      <= S_FIN;
            done       <= 1'b1;
            bus.vid_we <= 1'b0;
            busy       <= 1'b0;
          end else begin
            state        <= S_FETCH;
            fcnt         <= '0;
            bus.ram_addr <= base + ADDR_W'(TRI_WORDS);
          end
        end

        S_FIN: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase

      // The last divide (y3) completes on the launch edge, so ty3 takes it directly.
      if (launch_now) begin
        state          <= S_LAUNCH;
        bus.rast_reset <= 1'b1;
        bus.tx1        <= s[X1];
        bus.ty1        <= s[Y1];
        bus.tx2        <= s[X2];
        bus.ty2        <= s[Y2];
        bus.tx3        <= s[X3];
        bus.ty3        <= (state == S_PROJ) ? q_quot : s[Y3];
      end
    end
  end

endmodule

// File: tb/tb_tri_sequencer.sv
// Randomized bench for tri_sequencer against a cycle-count and arithmetic reference model.
module tb_tri_sequencer;
  import tri_pkg::*;

  localparam int AW       = 8;
  localparam int DW       = 32;
  localparam int PROJ_CYC = 6 * (2 * DW + 2);
  localparam int BUDGET   = 3000;

  logic          clk        = 1'b0;
  logic          reset      = 1'b0;
  logic          start      = 1'b0;
  logic          project_en = 1'b0;
  logic [AW-1:0] tri_count  = '0;
  logic          busy, done, div_err;
  state_t        state_dbg;

  int n_cmp = 0;
  int n_mis = 0;

  logic [DW-1:0]   mem [256];
  logic [6*DW-1:0] exp_q [$];

  tri_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  tri_sequencer #(.ADDR_W(AW), .DATA_W(DW), .PROJ_D(300)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tri_count  (tri_count),
    .project_en (project_en),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .div_err    (div_err),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset / RAM ----------------
  always #5 clk = ~clk;

  always @(posedge clk) bus.ram_data <= mem[bus.ram_addr];

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] proj(input logic [DW-1:0] c, input logic [DW-1:0] z);
    longint p, q;
    if (z == '0) return '0;
    p = longint'($signed(c)) * 64'sd300;
    q = p / longint'($signed(z));
    return q[DW-1:0];
  endfunction

  function automatic logic [6*DW-1:0] exp_tri(input int b, input bit pe);
    logic [DW-1:0] w [9];
    for (int k = 0; k < 9; k++) w[k] = mem[(b + k) % 256];
    if (pe)
      return {proj(w[0], w[2]), proj(w[1], w[2]), proj(w[3], w[5]),
              proj(w[4], w[5]), proj(w[6], w[8]), proj(w[7], w[8])};
    return {w[0], w[1], w[3], w[4], w[6], w[7]};
  endfunction

  function automatic bit has_zero(input int b);
    return (mem[(b + 2) % 256] == '0) || (mem[(b + 5) % 256] == '0) ||
           (mem[(b + 8) % 256] == '0);
  endfunction

  // ---------------- drivers ----------------
  function automatic logic [DW-1:0] rand_c();
    int v;
    v = int'($urandom_range(0, 20000)) - 10000;
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_z();
    int v;
    if ($urandom_range(0, 7) == 0) return '0;
    v = int'($urandom_range(1, 200));
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  task automatic fill_random();
    for (int a = 0; a < 256; a++)
      mem[a] = ((a % 9) inside {2, 5, 8}) ? rand_z() : rand_c();
  endtask

  task automatic set_tri(input int b, input int x1, input int y1, input int z1,
                         input int x2, input int y2, input int z2,
                         input int x3, input int y3, input int z3);
    mem[b]     = x1; mem[b + 1] = y1; mem[b + 2] = z1;
    mem[b + 3] = x2; mem[b + 4] = y2; mem[b + 5] = z2;
    mem[b + 6] = x3; mem[b + 7] = y3; mem[b + 8] = z3;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_ram_addr"}, bus.ram_addr, 0);
    check({pfx, "_tx1"}, bus.tx1, 0);
    check({pfx, "_ty1"}, bus.ty1, 0);
    check({pfx, "_tx2"}, bus.tx2, 0);
    check({pfx, "_ty2"}, bus.ty2, 0);
    check({pfx, "_tx3"}, bus.tx3, 0);
    check({pfx, "_ty3"}, bus.ty3, 0);
    check({pfx, "_rast_reset"}, bus.rast_reset, 0);
    check({pfx, "_vid_we"}, bus.vid_we, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_div_err"}, div_err, 0);
    check({pfx, "_state"}, state_dbg, S_IDLE);
  endtask

  // One full draw pass. rel counts cycles after the start-accept edge (rel 1 = first
  // cycle after it). The rasterizer model raises finish in the stale cycle after each
  // launch and from launch+d on (or always, when hold is set).
  task automatic run_job(input int n, input bit pe, input int d, input bit hold);
    int rel, L, exp_launch, exp_done, fetch_start, base, launches, dones, p_cyc;
    bit any_z;
    logic [AW-1:0]   addr_before;
    logic [6*DW-1:0] e;
    p_cyc = pe ? PROJ_CYC : 0;
    any_z = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_tri((i * 9) % 256, pe));
      if (pe && has_zero((i * 9) % 256)) any_z = 1'b1;
    end
    exp_launch  = 11 + p_cyc;
    fetch_start = (n == 0) ? -100 : 1;
    exp_done    = (n == 0) ? 1 : -1;
    base        = 0;
    L           = -100;
    launches    = 0;
    dones       = 0;

    @(negedge clk);
    addr_before = bus.ram_addr;
    start       = 1'b1;
    tri_count   = AW'(n);
    project_en  = pe;
    @(negedge clk);
    start = 1'b0;

    for (rel = 1; rel <= BUDGET; rel++) begin
      if (rel > 1) @(negedge clk);
      if (rel == 1) begin
        check("div_err_clear", div_err, 0);
        if (n == 0) check("n0_addr_idle", bus.ram_addr, addr_before);
      end
      if (rel == fetch_start) check("fetch_addr_k0", bus.ram_addr, AW'(base));
      if (rel == fetch_start + 8) check("fetch_addr_k8", bus.ram_addr, AW'((base + 8) % 256));
      if (bus.rast_reset) begin
        launches++;
        check("launch_time", rel, exp_launch);
        check("launch_vid_we", bus.vid_we, 1);
        check("launch_busy", busy, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tx1", bus.tx1, e[6*DW-1 -: DW]);
          check("ty1", bus.ty1, e[5*DW-1 -: DW]);
          check("tx2", bus.tx2, e[4*DW-1 -: DW]);
          check("ty2", bus.ty2, e[3*DW-1 -: DW]);
          check("tx3", bus.tx3, e[2*DW-1 -: DW]);
          check("ty3", bus.ty3, e[DW-1 -: DW]);
        end
        L = rel;
        if (launches < n) begin
          exp_launch  = L + d + 12 + p_cyc;
          fetch_start = L + d + 2;
          base        = (base + 9) % 256;
        end else begin
          exp_done = L + d + 2;
        end
      end
      if (done) begin
        dones++;
        check("done_time", rel, exp_done);
        check("done_vid_we", bus.vid_we, 0);
        check("done_busy", busy, 0);
        check("done_div_err", div_err, any_z);
        break;
      end
      bus.rast_finish = hold || (L > 0 && (rel == L + 1 || rel >= L + d));
      start = (rel == 5);
    end
    check("done_seen", dones, 1);
    check("launch_count", launches, n);
    @(negedge clk);
    check("done_pulse_width", done, 0);
    bus.rast_finish = 1'b0;
    start = 1'b0;
  endtask

  task automatic reset_mid_wait();
    int i;
    fill_random();
    @(negedge clk);
    start = 1'b1; tri_count = AW'(2); project_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (i = 0; i < 200; i++) begin
      if (bus.rast_reset) break;
      @(negedge clk);
    end
    check("rst_test_launch", bus.rast_reset, 1);
    @(negedge clk);
    check("rst_test_in_wait", state_dbg, S_WAIT);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    reset = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.rast_finish = 1'b0;
    fill_random();
    repeat (3) @(negedge clk);
    check_idle_outputs("por");
    reset = 1'b1;

    set_tri(0, 10, 20, 5, 100, 20, 5, 50, 80, 5);
    run_job(1, 1'b0, 2, 1'b0);
    run_job(1, 1'b1, 2, 1'b0);

    set_tri(0, -1, 20, 7, 100, 20, 5, 50, 80, 5);
    run_job(1, 1'b1, 3, 1'b0);
    set_tri(0, -7, 20, 4, 100, 20, 5, 50, 80, 5);
    run_job(1, 1'b1, 2, 1'b0);

    set_tri(0, 10, 20, 5, 100, 20, 0, 50, 80, 5);
    run_job(1, 1'b1, 4, 1'b0);
    repeat (3) @(negedge clk);
    check("div_err_sticky", div_err, 1);

    fill_random();
    run_job(3, 1'b0, 2, 1'b1);

    for (int j = 0; j < 4; j++) begin
      fill_random();
      run_job(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
              int'($urandom_range(2, 6)), 1'b0);
    end

    reset_mid_wait();
    fill_random();
    run_job(2, 1'b1, int'($urandom_range(2, 5)), 1'b0);

    run_job(0, 1'b0, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
